// File: rtl/encoder_phase_sequencer_if.sv
// Host start handshake plus engine command/completion bus of the encoder phase sequencer.
// The master modport is the sequencer side, the slave modport is the host/engine side.
interface encoder_phase_sequencer_if #(
  parameter int SEQ_LEN    = 8,
  parameter int HEADS      = 4,
  parameter int NUM_LAYERS = 2
);
  localparam int HW = (HEADS > 1) ? $clog2(HEADS) : 1;
  localparam int RW = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
  localparam int LW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

  logic          start_valid;
  logic          start_ready;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_phase;
  logic [HW-1:0] cmd_head;
  logic [RW-1:0] cmd_row;
  logic [LW-1:0] cmd_layer;
  logic          cmd_last;
  logic          eng_done;

  modport master (
    input  start_valid,
    output start_ready,
    output cmd_valid,
    input  cmd_ready,
    output cmd_phase,
    output cmd_head,
    output cmd_row,
    output cmd_layer,
    output cmd_last,
    input  eng_done
  );

  modport slave (
    output start_valid,
    input  start_ready,
    input  cmd_valid,
    output cmd_ready,
    input  cmd_phase,
    input  cmd_head,
    input  cmd_row,
    input  cmd_layer,
    input  cmd_last,
    output eng_done
  );
endinterface

// File: rtl/encoder_phase_sequencer.sv
// Encoder phase sequencer: walks layer -> phase -> head -> row and issues one engine
// command at a time, waiting for eng_done before moving on.
// Optional macro ENC_SEQ_PERF_EN adds the perf_cycles busy-cycle counter port.
//
// state  | meaning
// IDLE   | waiting for start_valid, start_ready high
// ISSUE  | command presented on cmd_*, waiting for cmd_ready
// WAIT   | command accepted, waiting for the engine completion pulse
// DONE   | one-cycle completion pulse, then back to IDLE
module encoder_phase_sequencer #(
  parameter int SEQ_LEN    = 8,
  parameter int HEADS      = 4,
  parameter int NUM_LAYERS = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  encoder_phase_sequencer_if.master  bus,
  input  logic                       abort,
  output logic                       busy,
  output logic                       done,
  output logic                       proto_err
`ifdef ENC_SEQ_PERF_EN
  ,
  output logic [31:0]                perf_cycles
`endif
);
  localparam int HW = (HEADS > 1) ? $clog2(HEADS) : 1;
  localparam int RW = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
  localparam int LW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

  localparam logic [RW-1:0] ROW_MAX   = RW'(SEQ_LEN - 1);
  localparam logic [HW-1:0] HEAD_MAX  = HW'(HEADS - 1);
  localparam logic [LW-1:0] LAYER_MAX = LW'(NUM_LAYERS - 1);
  localparam logic [2:0]    PH_RESID  = 3'd6;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [2:0]    phase;
  logic [HW-1:0] head;
  logic [RW-1:0] row;
  logic [LW-1:0] layer;
  logic          start_acc;
  logic          advance;
  logic          row_end;
  logic          head_end;
  logic          last_cmd;

  assign start_acc = (state == S_IDLE) && bus.start_valid && !abort;
  assign advance   = (state == S_WAIT) && bus.eng_done && !abort;
  assign row_end   = (row == ROW_MAX);
  // only the score and attention*V phases iterate over heads
  assign head_end  = !((phase == 3'd1) || (phase == 3'd2)) || (head == HEAD_MAX);
  assign last_cmd  = (layer == LAYER_MAX) && (phase == PH_RESID) && row_end;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // next-state decode; abort overrides every other input
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (bus.start_valid) state_nxt = S_ISSUE;
        S_ISSUE: if (bus.cmd_ready)   state_nxt = S_WAIT;
        S_WAIT:  if (bus.eng_done)    state_nxt = last_cmd ? S_DONE : S_ISSUE;
        S_DONE:  state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // outputs decoded from registered state and counters only
  always_comb begin
    bus.start_ready = (state == S_IDLE);
    bus.cmd_valid   = (state == S_ISSUE);
    busy            = (state != S_IDLE);
    done            = (state == S_DONE);
    bus.cmd_phase   = phase;
    bus.cmd_head    = head;
    bus.cmd_row     = row;
    bus.cmd_layer   = layer;
    bus.cmd_last    = last_cmd;
  end

  // nested row/head/phase/layer counters; they return to zero after the final command
  always_ff @(posedge clk) begin
    if (rst || abort || start_acc || (advance && last_cmd)) begin
      phase <= '0;
      head  <= '0;
      row   <= '0;
      layer <= '0;
    end else if (advance) begin
      if (!row_end) begin
        row <= row + 1'b1;
      end else begin
        row <= '0;
        if (!head_end) begin
          head <= head + 1'b1;
        end else begin
          head <= '0;
          if (phase != PH_RESID) begin
            phase <= phase + 3'd1;
          end else begin
            phase <= '0;
            layer <= layer + 1'b1;
          end
        end
      end
    end
  end

  // sticky flag for completion pulses that arrive with no command outstanding
  always_ff @(posedge clk) begin
    if (rst)                                      proto_err <= 1'b0;
    else if (bus.eng_done && (state != S_WAIT))   proto_err <= 1'b1;
    else if (start_acc)                           proto_err <= 1'b0;
  end

`ifdef ENC_SEQ_PERF_EN
  // saturating busy-cycle counter; restarts on start accept, survives abort
  always_ff @(posedge clk) begin
    if (rst)                               perf_cycles <= '0;
    else if (start_acc)                    perf_cycles <= '0;
    else if (busy && (perf_cycles != '1))  perf_cycles <= perf_cycles + 32'd1;
  end
`endif
endmodule

// File: tb/tb_encoder_phase_sequencer.sv
// Scoreboard bench for encoder_phase_sequencer: expected command streams come from a
// loop-nest model of the layer/phase/head/row order; a negedge monitor pops and compares.
module tb_encoder_phase_sequencer;
  localparam int SEQ_LEN = 8;
  localparam int HEADS   = 4;
  localparam int NL      = 2;
  localparam int NCMD    = (5 * SEQ_LEN + 2 * HEADS * SEQ_LEN) * NL;

  typedef struct {
    int phase;
    int head;
    int row;
    int layer;
    int last;
  } cmd_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic abort = 1'b0;
  logic busy, done, proto_err;
`ifdef ENC_SEQ_PERF_EN
  logic [31:0] perf_cycles;
`endif

  encoder_phase_sequencer_if #(.SEQ_LEN(SEQ_LEN), .HEADS(HEADS), .NUM_LAYERS(NL)) bus ();

  encoder_phase_sequencer #(.SEQ_LEN(SEQ_LEN), .HEADS(HEADS), .NUM_LAYERS(NL)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .abort(abort),
    .busy(busy),
    .done(done),
    .proto_err(proto_err)
`ifdef ENC_SEQ_PERF_EN
    ,
    .perf_cycles(perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   passed = 0;
  int   cyc = 0;
  int   t0 = 0;
  int   n_acc = 0;
  cmd_t exp_q[$];

  bit rand_mode = 0, fixed_timing = 0, stall_mode = 0, inject_mode = 0, injected = 0;
  bit eng_flush = 0, acc_pend = 0, dly_active = 0, prev_stall = 0;
  int dly = 0, stall_left = 0, last_phase = 0, last_layer = 0;
  int sv_phase, sv_head, sv_row, sv_layer;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act === expv) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, expv);
  endtask

  task automatic fail(input string name, input int info);
    checks++;
    $display("FAIL %s: got %0d expected none", name, info);
  endtask

  // reference order: layer outermost, then phase, then head (phases 1,2 only), row innermost
  task automatic fill_model();
    cmd_t c;
    exp_q.delete();
    for (int l = 0; l < NL; l++)
      for (int p = 0; p < 7; p++)
        for (int h = 0; h < ((p == 1 || p == 2) ? HEADS : 1); h++)
          for (int r = 0; r < SEQ_LEN; r++) begin
            c.phase = p; c.head = h; c.row = r; c.layer = l;
            c.last  = (l == NL - 1 && p == 6 && r == SEQ_LEN - 1) ? 1 : 0;
            exp_q.push_back(c);
          end
  endtask

  always @(posedge clk) cyc++;

  // engine model: completion a fixed or random number of cycles after acceptance, plus ready stalls
  always @(posedge clk) begin
    #1;
    bus.eng_done = 1'b0;
    if (eng_flush) begin
      acc_pend   = 0;
      dly_active = 0;
    end else begin
      if (acc_pend) begin
        acc_pend   = 0;
        dly_active = 1;
        dly        = rand_mode ? int'($urandom_range(0, 3)) : 0;
      end
      if (dly_active) begin
        if (dly == 0) begin
          bus.eng_done = 1'b1;
          dly_active   = 0;
        end else dly--;
      end
    end
    if (stall_mode && n_acc == 3 && stall_left > 0 && bus.cmd_valid) begin
      bus.cmd_ready = 1'b0;
      stall_left--;
    end else if (inject_mode && !injected && n_acc == 10 && bus.cmd_valid) begin
      bus.cmd_ready = 1'b0;
      bus.eng_done  = 1'b1;
      injected      = 1;
    end else begin
      bus.cmd_ready = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // monitor: field stability under stall, command scoreboard, done against model
  always @(negedge clk) begin
    cmd_t e;
    if (rst) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", bus.cmd_valid, 1);
        check("stall_phase", bus.cmd_phase, sv_phase);
        check("stall_head", bus.cmd_head, sv_head);
        check("stall_row", bus.cmd_row, sv_row);
        check("stall_layer", bus.cmd_layer, sv_layer);
      end
      if (bus.cmd_valid && bus.cmd_ready) begin
        if (exp_q.size() == 0) begin
          fail("extra_cmd", n_acc);
        end else begin
          e = exp_q.pop_front();
          check("cmd_phase", bus.cmd_phase, e.phase);
          check("cmd_head", bus.cmd_head, e.head);
          check("cmd_row", bus.cmd_row, e.row);
          check("cmd_layer", bus.cmd_layer, e.layer);
          check("cmd_last", bus.cmd_last, e.last);
          if (fixed_timing) check("accept_cycle", cyc - t0, 1 + 2 * n_acc);
        end
        last_phase = bus.cmd_phase;
        last_layer = bus.cmd_layer;
        acc_pend   = 1;
        n_acc++;
      end
      prev_stall = bus.cmd_valid && !bus.cmd_ready;
      sv_phase = bus.cmd_phase; sv_head = bus.cmd_head;
      sv_row   = bus.cmd_row;   sv_layer = bus.cmd_layer;
      if (done) check("done_queue_empty", exp_q.size(), 0);
    end
  end

  task automatic check_idle(input string tag);
    check({tag, "_start_ready"}, bus.start_ready, 1);
    check({tag, "_cmd_valid"}, bus.cmd_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_proto_err"}, proto_err, 0);
    check({tag, "_fields"}, {bus.cmd_phase, 5'(bus.cmd_head), 5'(bus.cmd_row), 5'(bus.cmd_layer), bus.cmd_last}, 0);
  endtask

  task automatic start_run();
    fill_model();
    n_acc = 0;
    @(posedge clk); #1;
    bus.start_valid = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    bus.start_valid = 1'b0;
    check("busy_after_start", busy, 1);
    check("proto_clear_on_start", proto_err, 0);
  endtask

  task automatic wait_done(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      if (done) break;
      @(posedge clk); #1;
    end
    if (i == budget) begin
      fail("done_timeout", n_acc);
    end else begin
      if (fixed_timing) check("done_cycle", cyc - t0, 2 * NCMD + 1);
      check("total_cmds", n_acc, NCMD);
      @(posedge clk); #1;
      check("start_ready_after_done", bus.start_ready, 1);
      check("done_one_cycle", done, 0);
    end
  endtask

  initial begin
    bit saw_done;
    int i;
    bus.start_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    rst = 1'b0;

    fixed_timing = 1;
    start_run();
    wait_done(3000);
`ifdef ENC_SEQ_PERF_EN
    check("perf_cycles", perf_cycles, 2 * NCMD + 1);
`endif
    fixed_timing = 0;

    stall_mode = 1; stall_left = 5;
    start_run();
    wait_done(3000);
    check("stall_consumed", stall_left, 0);
    stall_mode = 0;

    inject_mode = 1; injected = 0;
    start_run();
    wait_done(3000);
    check("proto_err_sticky", proto_err, 1);
    inject_mode = 0;

    // abort in WAIT of layer 0 phase 4; the restart also clears proto_err
    start_run();
    for (i = 0; i < 3000; i++) begin
      if (busy && !bus.cmd_valid && !done && last_phase == 4 && last_layer == 0) break;
      @(posedge clk); #1;
    end
    if (i == 3000) fail("abort_wait_timeout", n_acc);
    abort = 1'b1;
    eng_flush = 1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_cmd_valid", bus.cmd_valid, 0);
    saw_done = done;
    repeat (4) begin
      @(posedge clk); #1;
      saw_done |= done;
    end
    check("abort_no_done", saw_done, 0);
    eng_flush = 0;
    exp_q.delete();

    fixed_timing = 1;
    start_run();
    wait_done(3000);
    fixed_timing = 0;

    rand_mode = 1;
    repeat (2) begin
      start_run();
      wait_done(8000);
    end
    rand_mode = 0;

    start_run();
    repeat (41) @(posedge clk);
    #1;
    rst = 1'b1;
    eng_flush = 1;
    @(posedge clk); #1;
    check_idle("midrun_reset");
`ifdef ENC_SEQ_PERF_EN
    check("midrun_reset_perf", perf_cycles, 0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    eng_flush = 0;
    exp_q.delete();
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
